// File: rtl/rgmii_phy_tx_decoder.sv
// -----------------------------------------------------------------------------
// rgmii_phy_tx_decoder
//
// PHY-side decoder for a MAC's RGMII transmit stream. Inputs are the per-cycle
// DDR samples of TXC/TXD/TX_CTL that the IDDR wrapper captures in the clk domain.
// The block rebuilds GMII bytes with a one-cycle valid strobe. It also infers
// the link speed from the measured TXC period.
//
// Parameters:
//   SPEED_CONFIRM  consecutive equal period classifications before speed_o moves
//   IDLE_TIMEOUT   clk cycles without a TXC rise before link_idle asserts (<= 63)
//
// Optional feature (compile-time macro RGMII_DEC_STATS_EN):
//   adds byte_count[31:0] and err_count[15:0] wrapping statistics outputs.
//
// Ports:
//   clk, rst                 125 MHz sample clock, synchronous active-high reset
//   in_clk_1 / in_clk_2      TXC sampled at clk rising / falling edge
//   in_d1 / in_d2            TXD sampled at clk rising / falling edge
//   in_ctl_1 / in_ctl_2      TX_CTL sampled at clk rising / falling edge
//   gmii_txd/_tx_en/_tx_er   reconstructed byte and its control bits
//   gmii_valid               one-cycle strobe per reconstructed byte
//   speed_o                  00 = 10M, 01 = 100M, 10 = 1000M
//   link_idle                no TXC rise for IDLE_TIMEOUT cycles
//   nibble_err               pulse: 10/100 frame ended on an odd nibble
// -----------------------------------------------------------------------------
module rgmii_phy_tx_decoder #(
    parameter int SPEED_CONFIRM = 2,
    parameter int IDLE_TIMEOUT  = 63
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_clk_1,
    input  logic       in_clk_2,
    input  logic [3:0] in_d1,
    input  logic [3:0] in_d2,
    input  logic       in_ctl_1,
    input  logic       in_ctl_2,
    output logic [7:0] gmii_txd,
    output logic       gmii_tx_en,
    output logic       gmii_tx_er,
    output logic       gmii_valid,
    output logic [1:0] speed_o,
    output logic       link_idle,
    output logic       nibble_err
`ifdef RGMII_DEC_STATS_EN
    ,
    output logic [31:0] byte_count,
    output logic [15:0] err_count
`endif
);

    typedef enum logic [1:0] {
        SPD_10   = 2'b00,
        SPD_100  = 2'b01,
        SPD_1000 = 2'b10,
        SPD_NONE = 2'b11   // unclassified period
    } speed_e;

    typedef enum logic {
        LOW_NIB  = 1'b0,
        HIGH_NIB = 1'b1
    } nib_state_e;

    localparam int                CONF_W   = $clog2(SPEED_CONFIRM + 1);
    localparam logic [CONF_W-1:0] CONF_MAX = CONF_W'(SPEED_CONFIRM);
    localparam logic [CONF_W-1:0] CONF_ONE = CONF_W'(1);
    localparam logic [5:0]        IDLE_CNT = 6'(IDLE_TIMEOUT);

    // State registers
    logic              prev_clk_2_q,   prev_clk_2_d;
    logic [5:0]        period_cnt_q,   period_cnt_d;
    speed_e            cand_q,         cand_d;
    logic [CONF_W-1:0] confirm_cnt_q,  confirm_cnt_d;
    speed_e            speed_q,        speed_d;
    logic              link_idle_q,    link_idle_d;
    nib_state_e        state_q,        state_d;
    logic [3:0]        nib_lat_q,      nib_lat_d;
    logic              en_lat_q,       en_lat_d;
    logic [3:0]        low_nib_q,      low_nib_d;
    logic              low_en_q,       low_en_d;
    logic              low_err_q,      low_err_d;
    logic [7:0]        txd_q,          txd_d;
    logic              tx_en_q,        tx_en_d;
    logic              tx_er_q,        tx_er_d;
    logic              valid_q,        valid_d;
    logic              nibble_err_q,   nibble_err_d;

    // Edge detection on the DDR TXC samples
    logic       rise;
    logic       fall;
    logic [6:0] period;       // count+1, can reach 64 when saturated
    speed_e     cls;
    logic       err_now;      // error bit carried by TX_CTL on the TXC low phase
    logic       nib_active;   // current nibble belongs to a frame or an error

    assign rise       = !prev_clk_2_q &&  in_clk_1;
    assign fall       =  prev_clk_2_q && !in_clk_1;
    assign period     = {1'b0, period_cnt_q} + 7'd1;
    assign err_now    = en_lat_q ^ in_ctl_1;
    assign nib_active = en_lat_q | err_now;

    always_comb begin
        cls = SPD_NONE;
        if (period == 7'd1) begin
            cls = SPD_1000;
        end else if (period >= 7'd4 && period <= 7'd6) begin
            cls = SPD_100;
        end else if (period >= 7'd45 && period <= 7'd55) begin
            cls = SPD_10;
        end
    end

    always_comb begin
        // NOTE: every _d starts from its _q (or a pulse default) so no branch can infer a latch.
        prev_clk_2_d  = in_clk_2;
        period_cnt_d  = period_cnt_q;
        cand_d        = cand_q;
        confirm_cnt_d = confirm_cnt_q;
        speed_d       = speed_q;
        link_idle_d   = link_idle_q;
        state_d       = state_q;
        nib_lat_d     = nib_lat_q;
        en_lat_d      = en_lat_q;
        low_nib_d     = low_nib_q;
        low_en_d      = low_en_q;
        low_err_d     = low_err_q;
        txd_d         = txd_q;
        tx_en_d       = tx_en_q;
        tx_er_d       = tx_er_q;
        valid_d       = 1'b0;
        nibble_err_d  = 1'b0;

        if (rise) begin
            period_cnt_d = 6'd0;
            link_idle_d  = 1'b0;
            // Nibble latch is taken on every rise so it is fresh whatever the speed.
            nib_lat_d    = in_d1;
            en_lat_d     = in_ctl_1;

            if (cls == SPD_NONE) begin
                cand_d        = SPD_NONE;
                confirm_cnt_d = '0;
            end else if (cls == cand_q) begin
                if (confirm_cnt_q != CONF_MAX) begin
                    confirm_cnt_d = confirm_cnt_q + CONF_ONE;
                end
            end else begin
                cand_d        = cls;
                confirm_cnt_d = CONF_ONE;
            end
            if (cls != SPD_NONE && confirm_cnt_d >= CONF_MAX) begin
                speed_d = cls;
            end

            // Gigabit: one full byte per TXC period, both DDR halves together.
            if (speed_q == SPD_1000) begin
                txd_d   = {in_d2, in_d1};
                tx_en_d = in_ctl_1;
                tx_er_d = in_ctl_1 ^ in_ctl_2;
                valid_d = 1'b1;
            end
        end else begin
            if (period_cnt_q != 6'd63) begin
                period_cnt_d = period_cnt_q + 6'd1;
            end
            if (period_cnt_d == IDLE_CNT) begin
                link_idle_d = 1'b1;
            end
        end

        // Nibble pairing runs only at 10/100 on an active link; a speed
        // change drops any half-assembled byte without a nibble_err.
        if (speed_q == SPD_1000 || link_idle_q || speed_d != speed_q) begin
            state_d = LOW_NIB;
        end else if (fall) begin
            unique case (state_q)
                LOW_NIB: begin
                    if (nib_active) begin
                        low_nib_d = nib_lat_q;
                        low_en_d  = en_lat_q;
                        low_err_d = err_now;
                        state_d   = HIGH_NIB;
                    end
                end
                HIGH_NIB: begin
                    if (nib_active) begin
                        txd_d   = {nib_lat_q, low_nib_q};
                        tx_en_d = low_en_q & en_lat_q;
                        tx_er_d = low_err_q | err_now;
                        valid_d = 1'b1;
                    end else begin
                        nibble_err_d = 1'b1;
                    end
                    state_d = LOW_NIB;
                end
                default: state_d = LOW_NIB;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: reset is sampled on the clock edge, so it lives inside the clocked branch.
        if (rst) begin
            prev_clk_2_q  <= 1'b0;
            period_cnt_q  <= 6'd0;
            cand_q        <= SPD_NONE;
            confirm_cnt_q <= '0;
            speed_q       <= SPD_1000;
            link_idle_q   <= 1'b1;
            state_q       <= LOW_NIB;
            nib_lat_q     <= 4'd0;
            en_lat_q      <= 1'b0;
            low_nib_q     <= 4'd0;
            low_en_q      <= 1'b0;
            low_err_q     <= 1'b0;
            txd_q         <= 8'd0;
            tx_en_q       <= 1'b0;
            tx_er_q       <= 1'b0;
            valid_q       <= 1'b0;
            nibble_err_q  <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments keep every flop updating from pre-edge values.
            prev_clk_2_q  <= prev_clk_2_d;
            period_cnt_q  <= period_cnt_d;
            cand_q        <= cand_d;
            confirm_cnt_q <= confirm_cnt_d;
            speed_q       <= speed_d;
            link_idle_q   <= link_idle_d;
            state_q       <= state_d;
            nib_lat_q     <= nib_lat_d;
            en_lat_q      <= en_lat_d;
            low_nib_q     <= low_nib_d;
            low_en_q      <= low_en_d;
            low_err_q     <= low_err_d;
            txd_q         <= txd_d;
            tx_en_q       <= tx_en_d;
            tx_er_q       <= tx_er_d;
            valid_q       <= valid_d;
            nibble_err_q  <= nibble_err_d;
        end
    end

    assign gmii_txd   = txd_q;
    assign gmii_tx_en = tx_en_q;
    assign gmii_tx_er = tx_er_q;
    assign gmii_valid = valid_q;
    assign speed_o    = speed_q;
    assign link_idle  = link_idle_q;
    assign nibble_err = nibble_err_q;

`ifdef RGMII_DEC_STATS_EN
    logic [31:0] byte_count_q, byte_count_d;
    logic [15:0] err_count_q,  err_count_d;

    // Counted from the _d side so the counters step together with the strobes.
    always_comb begin
        byte_count_d = byte_count_q + 32'(valid_d & tx_en_d);
        err_count_d  = err_count_q + 16'(valid_d & tx_er_d) + 16'(nibble_err_d);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            byte_count_q <= 32'd0;
            err_count_q  <= 16'd0;
        end else begin
            byte_count_q <= byte_count_d;
            err_count_q  <= err_count_d;
        end
    end

    assign byte_count = byte_count_q;
    assign err_count  = err_count_q;
`endif

endmodule
